// File: rtl/mfp_adc_max10_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mfp_adc_max10_arbiter
// Brief    : Packet-level round-robin arbiter sharing one MAX10 ADC
//            command/response stream pair between several requesters.
//            A requester owns the command channel for a whole SOP..EOP
//            packet; responses route back to the owner until the response
//            EOP or a watchdog timeout releases ownership.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_adc_max10_arbiter #(
    parameter int REQ_COUNT = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [REQ_COUNT-1:0]   REQ_C_Valid,
    input  logic [5*REQ_COUNT-1:0] REQ_C_Channel,
    input  logic [REQ_COUNT-1:0]   REQ_C_SOP,
    input  logic [REQ_COUNT-1:0]   REQ_C_EOP,
    output logic [REQ_COUNT-1:0]   REQ_C_Ready,
    output logic [REQ_COUNT-1:0]   REQ_R_Valid,
    output logic [4:0]             REQ_R_Channel,
    output logic [11:0]            REQ_R_Data,
    output logic                   REQ_R_SOP,
    output logic                   REQ_R_EOP,
    output logic                   ADC_C_Valid,
    output logic                   ADC_C_SOP,
    output logic                   ADC_C_EOP,
    output logic [4:0]             ADC_C_Channel,
    input  logic                   ADC_C_Ready,
    input  logic                   ADC_R_Valid,
    input  logic                   ADC_R_SOP,
    input  logic                   ADC_R_EOP,
    input  logic [4:0]             ADC_R_Channel,
    input  logic [11:0]            ADC_R_Data,
    output logic [1:0]             Owner,
    output logic                   Busy,
    output logic                   Timeout
);

    localparam logic [9:0] c_WDOG_LAST = 10'(TIMEOUT - 1);
    localparam logic [2:0] c_REQ_N     = 3'(REQ_COUNT);
    localparam logic [1:0] c_LAST_RST  = 2'(REQ_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_owner;
    logic [1:0] r_last;
    logic [9:0] r_wdog;
    logic       r_timeout;

    // Requester inputs widened to four slots so a 2-bit owner index is always in range
    logic [3:0] w_valid4;
    logic [3:0] w_sop4;
    logic [3:0] w_eop4;
    logic [4:0] w_chan4 [4];
    logic [3:0] w_cand4;
    logic [2:0] w_idx;
    logic [1:0] w_pick;
    logic       w_found;
    logic       w_in_cmd;
    logic       w_active;
    logic       w_own_valid;
    logic       w_own_sop;
    logic       w_own_eop;
    logic [4:0] w_own_chan;
    logic [3:0] w_ready4;
    logic [3:0] w_rvalid4;

    // Pad the per-requester buses out to four slots; missing requesters read as idle
    always_comb begin
        w_valid4 = '0;
        w_sop4   = '0;
        w_eop4   = '0;
        for (int i = 0; i < 4; i++) begin
            w_chan4[i] = '0;
        end
        for (int i = 0; i < REQ_COUNT; i++) begin
            w_valid4[i] = REQ_C_Valid[i];
            w_sop4[i]   = REQ_C_SOP[i];
            w_eop4[i]   = REQ_C_EOP[i];
            w_chan4[i]  = REQ_C_Channel[5*i +: 5];
        end
    end

    assign w_cand4 = w_valid4 & w_sop4;

    // Round-robin search from last+1 upward; descending loop lets the nearest candidate win
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = REQ_COUNT; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + 3'(k);
            if (w_idx >= c_REQ_N) begin
                w_idx = w_idx - c_REQ_N;
            end
            if (w_cand4[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[1:0];
            end
        end
    end

    assign w_in_cmd    = (r_state == ST_CMD);
    assign w_active    = (r_state != ST_IDLE);
    assign w_own_valid = w_valid4[r_owner];
    assign w_own_sop   = w_sop4[r_owner];
    assign w_own_eop   = w_eop4[r_owner];
    assign w_own_chan  = w_chan4[r_owner];

    // Only the owner sees ADC ready (in CMD) and response valid (in CMD or WAIT)
    always_comb begin
        w_ready4  = '0;
        w_rvalid4 = '0;
        if (w_in_cmd) begin
            w_ready4[r_owner] = ADC_C_Ready;
        end
        if (w_active) begin
            w_rvalid4[r_owner] = ADC_R_Valid;
        end
    end

    assign ADC_C_Valid   = w_in_cmd & w_own_valid;
    assign ADC_C_SOP     = w_in_cmd & w_own_sop;
    assign ADC_C_EOP     = w_in_cmd & w_own_eop;
    assign ADC_C_Channel = w_in_cmd ? w_own_chan : 5'd0;

    assign REQ_C_Ready   = w_ready4[REQ_COUNT-1:0];
    assign REQ_R_Valid   = w_rvalid4[REQ_COUNT-1:0];
    assign REQ_R_Channel = ADC_R_Channel;
    assign REQ_R_Data    = ADC_R_Data;
    assign REQ_R_SOP     = ADC_R_SOP;
    assign REQ_R_EOP     = ADC_R_EOP;

    assign Owner   = r_owner;
    assign Busy    = w_active;
    assign Timeout = r_timeout;

    // Ownership FSM: grant on SOP, hold through command EOP, release on response EOP or watchdog
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_last    <= c_LAST_RST;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_own_valid && w_own_eop && ADC_C_Ready) begin
                        r_state <= ST_WAIT;
                        r_wdog  <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ADC_R_Valid) begin
                        // Any response proves the ADC is alive; a response EOP wins over expiry
                        r_wdog <= '0;
                        if (ADC_R_EOP) begin
                            r_state <= ST_IDLE;
                            r_last  <= r_owner;
                        end
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_state   <= ST_IDLE;
                        r_last    <= r_owner;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 10'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mfp_adc_max10_arbiter.md
# mfp_adc_max10_arbiter

Packet-level arbiter that shares the single MAX10 ADC command/response stream pair between several independent requesters, for example the register-driven ADC core and a DMA/timer sampler. It sits between the requesters' Avalon-ST command/response ports and the ADC IP. It grants the command channel to one requester for a whole SOP..EOP packet and routes that packet's responses back to the owner only. Ownership is released on the response EOP or on a watchdog timeout.

## Interface
- REQ_COUNT, 2, number of requesters; legal range 2..4.
- TIMEOUT, 1023, response watchdog limit in cycles; 10-bit counter, legal range 1..1023.

- CLK  in  1  clock.
- RESETn  in  1  reset; asynchronous assert, active-low.
- REQ_C_Valid  in  REQ_COUNT  per-requester command valid.
- REQ_C_Channel  in  5*REQ_COUNT  per-requester channel; requester i occupies bits [5i+4:5i].
- REQ_C_SOP, REQ_C_EOP  in  REQ_COUNT  per-requester packet delimiters.
- REQ_C_Ready  out  REQ_COUNT  per-requester command ready.
- REQ_R_Valid  out  REQ_COUNT  per-requester response valid; one-hot or zero.
- REQ_R_Channel  out  5  response channel, broadcast to all requesters.
- REQ_R_Data  out  12  response data, broadcast.
- REQ_R_SOP, REQ_R_EOP  out  1  response delimiters, broadcast.
- ADC_C_Valid, ADC_C_SOP, ADC_C_EOP  out  1  command to the ADC.
- ADC_C_Channel  out  5  command channel to the ADC.
- ADC_C_Ready  in  1  ADC command ready.
- ADC_R_Valid, ADC_R_SOP, ADC_R_EOP  in  1  ADC response strobes.
- ADC_R_Channel  in  5  ADC response channel.
- ADC_R_Data  in  12  ADC response data.
- Owner  out  2  index of the current or last owner (status).
- Busy  out  1  high in CMD or WAIT.
- Timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, CMD, WAIT. Registered state `Owner`; registered `Last` (last owner); 10-bit `Wdog` counter.
- IDLE:
  - Candidates are requesters with REQ_C_Valid & REQ_C_SOP.
  - Round-robin pick: the first candidate searching upward from Last+1, wrapping modulo REQ_COUNT.
  - If a candidate exists: Owner <= pick, go to CMD. Otherwise stay in IDLE.
  - All REQ_C_Ready = 0; ADC_C_Valid = 0.
- CMD:
  - ADC_C_Valid/Channel/SOP/EOP = Owner's inputs.
  - REQ_C_Ready[Owner] = ADC_C_Ready; all other REQ_C_Ready = 0.
  - Handshake with EOP (owner valid & EOP & ADC_C_Ready) -> WAIT, Wdog <= 0.
- WAIT:
  - ADC_C_Valid = 0.
  - Wdog increments every cycle and is cleared on any ADC_R_Valid.
  - ADC_R_Valid & ADC_R_EOP -> IDLE, Last <= Owner.
  - Wdog == TIMEOUT-1 with no ADC_R_Valid -> IDLE, Last <= Owner, Timeout pulse.
- Response routing:
  - In CMD or WAIT: REQ_R_Valid[Owner] = ADC_R_Valid, combinational pass-through.
  - Responses arriving in CMD are forwarded; a response EOP in CMD does not change state.
  - In IDLE: responses are dropped and REQ_R_Valid = 0.
  - Data, channel, SOP and EOP are broadcast unmodified in every state.
- Non-owner requesters see Ready = 0 and must hold their packet. A requester asserting Valid without SOP in IDLE is not a candidate, and its Ready stays 0.
- Requester indices >= REQ_COUNT never exist; Owner upper bits read 0 when REQ_COUNT = 2.

## Timing
- Reset values: state IDLE, Owner = 0, Last = REQ_COUNT-1 (requester 0 wins first), Wdog = 0. All outputs 0: Busy, Timeout, every Valid and Ready, ADC_C_Channel.
- Grant latency: a candidate in IDLE at cycle t drives ADC_C_Valid at t+1.
- Single-channel packet accepted at t+1 -> WAIT from t+2.
- Release: a response EOP at cycle r gives IDLE at r+1; a new grant is visible at r+2. There is always at least one idle cycle between packets.
- Command path is combinational from requester to ADC in CMD. Ready path is combinational from ADC_C_Ready to REQ_C_Ready[Owner].
- Simultaneous events:
  - Response EOP and watchdog expiry in the same cycle: treated as a normal release, no Timeout pulse.
  - ADC_R_Valid clears Wdog in the same cycle it would otherwise expire.
- Reset mid-packet: immediate return to IDLE with all outputs low. Requesters must restart at SOP.

## Test plan
- Single request: req0 sends a 1-word packet (SOP=EOP=1, ch 3), ADC ready; ADC replies with EOP, data 0x5A5 -> ADC_C_Channel=3 one cycle after request, REQ_R_Valid=2'b01 with data 0x5A5, Busy falls the cycle after the reply.
- Contention: req0 and req1 both hold SOP from reset -> req0 is granted first; after its reply EOP, req1 is granted 2 cycles later. Repeat -> alternation 0,1,0,1.
- Multi-word packet: req1 sends ch 1,2,17 (SOP on the first word, EOP on the last) while ADC_C_Ready toggles -> ADC receives exactly 3 commands in order; req0 Ready stays 0 throughout; responses in CMD route only to REQ_R_Valid[1].
- Watchdog: TIMEOUT=8, no response after packet EOP -> Timeout pulses 8 cycles after entering WAIT; state returns to IDLE; a late response is dropped.
- Stray responses: ADC_R_Valid asserted in IDLE -> REQ_R_Valid stays 0.
- Reset mid-CMD: assert RESETn=0 during a 3-word packet -> ADC_C_Valid is 0 immediately; after release, req0 wins the next arbitration.
